// File: rtl/aes_uart_pkg.sv
// rtl/aes_uart_pkg.sv - shared types and defaults for the AES/UART frame sequencer
//
// Purpose: sequencer state encoding, default sizing and the byte type used
// by the frame sequencer and its bench.
// Ports: none (package).
package aes_uart_pkg;

  localparam int N_DATA_BITS_DEFAULT = 8;
  localparam int N_BYTES_DEFAULT     = 16;
  localparam int GAP_TIMEOUT_DEFAULT = 1_000_000;

  typedef logic [N_DATA_BITS_DEFAULT-1:0] byte_t;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    START    = 2'd1,
    WAIT_AES = 2'd2,
    SEND     = 2'd3
  } seq_state_t;

endpackage

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - inter-byte gap timer for partial RX frames
//
// Purpose: counts idle cycles while enabled and raises a one-cycle expire
// when GAP_TIMEOUT idle cycles have elapsed since the last clear.
// Ports:
//   clk_i     system clock
//   reset_i   synchronous active-high reset
//   clear_i   restart the count (a byte arrived or no partial frame)
//   enable_i  an idle cycle inside a partial frame
//   expire_o  combinational expiry strobe, valid in the expiring cycle
module uart_gap_timer #(
  parameter int GAP_TIMEOUT = 1_000_000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int            CW   = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(GAP_TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // The count is the number of idle cycles already seen before this one, so
  // the GAP_TIMEOUT-th idle cycle is the one where the count equals LAST.
  always_comb begin
    expire_o = enable_i && !clear_i && (count_q == LAST);
    count_d  = count_q;
    if (clear_i || expire_o) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/aes_uart_frame_sequencer.sv
// rtl/aes_uart_frame_sequencer.sv - one AES block round-trip over UART
//
// Purpose: gathers N_BYTES RX bytes into a block, pulses the AES start,
// waits for the AES result and streams it back out with valid/ready.
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_rx_data, i_rx_valid           received byte stream (one-cycle pulses)
//   o_aes_block, o_aes_start        assembled block and start pulse to AES
//   i_aes_done, i_aes_result        AES completion pulse and result block
//   o_tx_data, o_tx_valid, i_tx_ready  TX byte stream handshake
//   o_busy                          high unless idle with no partial frame
//   o_frame_done                    pulse after the last TX byte is accepted
//   o_frame_error                   pulse when a partial frame times out
//   o_rx_overrun                    pulse when an RX byte is dropped
module aes_uart_frame_sequencer
  import aes_uart_pkg::*;
#(
  parameter int N_DATA_BITS = N_DATA_BITS_DEFAULT,
  parameter int N_BYTES     = N_BYTES_DEFAULT,
  parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEFAULT
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [N_DATA_BITS-1:0]         i_rx_data,
  input  logic                           i_rx_valid,
  output logic [N_DATA_BITS*N_BYTES-1:0] o_aes_block,
  output logic                           o_aes_start,
  input  logic                           i_aes_done,
  input  logic [N_DATA_BITS*N_BYTES-1:0] i_aes_result,
  output logic [N_DATA_BITS-1:0]         o_tx_data,
  output logic                           o_tx_valid,
  input  logic                           i_tx_ready,
  output logic                           o_busy,
  output logic                           o_frame_done,
  output logic                           o_frame_error,
  output logic                           o_rx_overrun
);

  localparam int               IDX_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam int               BLK_W    = N_DATA_BITS * N_BYTES;

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] tx_idx_q, tx_idx_d;
  logic [BLK_W-1:0] aes_block_q, aes_block_d;
  logic [BLK_W-1:0] tx_buf_q, tx_buf_d;
  logic             tx_valid_q, tx_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_error_q, frame_error_d;
  logic             rx_overrun_q, rx_overrun_d;

  logic gap_enable;
  logic gap_clear;
  logic gap_expire;

  // The timer only runs on idle cycles of a partial frame; any byte, or
  // leaving COLLECT, restarts it so a new frame always gets a full window.
  assign gap_enable = (state_q == COLLECT) && (idx_q != '0) && !i_rx_valid;
  assign gap_clear  = i_rx_valid || (state_q != COLLECT);

  uart_gap_timer #(
    .GAP_TIMEOUT(GAP_TIMEOUT)
  ) u_gap_timer (
    .clk_i   (i_clk),
    .reset_i (i_reset),
    .clear_i (gap_clear),
    .enable_i(gap_enable),
    .expire_o(gap_expire)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tx_idx_d      = tx_idx_q;
    aes_block_d   = aes_block_q;
    tx_buf_d      = tx_buf_q;
    tx_valid_d    = tx_valid_q;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    rx_overrun_d  = 1'b0;

    case (state_q)
      COLLECT: begin
        // A byte on the expiry cycle suppresses the expiry (the timer
        // sees it as a clear), so it simply extends the frame.
        if (i_rx_valid) begin
          aes_block_d[int'(idx_q)*N_DATA_BITS +: N_DATA_BITS] = i_rx_data;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = START;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (gap_expire) begin
          idx_d         = '0;
          frame_error_d = 1'b1;
        end
      end
      START: begin
        state_d = WAIT_AES;
      end
      WAIT_AES: begin
        if (i_aes_done) begin
          tx_buf_d   = i_aes_result;
          tx_idx_d   = '0;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_valid_q && i_tx_ready) begin
          if (tx_idx_q == LAST_IDX) begin
            tx_valid_d   = 1'b0;
            frame_done_d = 1'b1;
            tx_idx_d     = '0;
            idx_d        = '0;
            state_d      = COLLECT;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase

    if (i_rx_valid && (state_q != COLLECT)) begin
      rx_overrun_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= COLLECT;
      idx_q         <= '0;
      tx_idx_q      <= '0;
      aes_block_q   <= '0;
      tx_buf_q      <= '0;
      tx_valid_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tx_idx_q      <= tx_idx_d;
      aes_block_q   <= aes_block_d;
      tx_buf_q      <= tx_buf_d;
      tx_valid_q    <= tx_valid_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

  // All outputs come straight from registers; ready never reaches valid.
  assign o_aes_block   = aes_block_q;
  assign o_aes_start   = (state_q == START);
  assign o_tx_data     = tx_buf_q[int'(tx_idx_q)*N_DATA_BITS +: N_DATA_BITS];
  assign o_tx_valid    = tx_valid_q;
  assign o_busy        = !((state_q == COLLECT) && (idx_q == '0));
  assign o_frame_done  = frame_done_q;
  assign o_frame_error = frame_error_q;
  assign o_rx_overrun  = rx_overrun_q;

endmodule

// File: tb/tb_aes_uart_frame_sequencer.sv
// tb/tb_aes_uart_frame_sequencer.sv - self-checking bench for the AES/UART frame sequencer
module tb_aes_uart_frame_sequencer;
  import aes_uart_pkg::*;

  localparam int N  = 16;
  localparam int G  = 50;
  localparam int P_COLLECT = 0;
  localparam int P_AWAIT   = 1;
  localparam int P_SEND    = 2;

  logic         clk;
  logic         i_reset;
  byte_t        i_rx_data;
  logic         i_rx_valid;
  logic [127:0] o_aes_block;
  logic         o_aes_start;
  logic         i_aes_done;
  logic [127:0] i_aes_result;
  byte_t        o_tx_data;
  logic         o_tx_valid;
  logic         i_tx_ready;
  logic         o_busy;
  logic         o_frame_done;
  logic         o_frame_error;
  logic         o_rx_overrun;

  aes_uart_frame_sequencer #(
    .N_DATA_BITS(8),
    .N_BYTES    (N),
    .GAP_TIMEOUT(G)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_aes_block  (o_aes_block),
    .o_aes_start  (o_aes_start),
    .i_aes_done   (i_aes_done),
    .i_aes_result (i_aes_result),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_frame_error(o_frame_error),
    .o_rx_overrun (o_rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Reference model state: what the sequencer should be doing in spec terms.
  int           phase;
  byte_t        frame_q[$];
  byte_t        got_q[$];
  int           idle_cnt;
  int           sent_cnt;
  int           cyc;
  int           first_hs_cyc;
  int           last_hs_cyc;
  int           n_ferr_dut;
  int           n_ferr_exp;
  int           n_ovr_dut;
  int           n_ovr_exp;
  logic [127:0] model_blk;
  logic [127:0] exp_tx;
  logic [127:0] res;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] pack_q(input byte_t q[$]);
    logic [127:0] b = '0;
    for (int k = 0; k < q.size() && k < N; k++) b[k*8 +: 8] = q[k];
    return b;
  endfunction

  // One clock cycle: drive RX, predict from the model, advance, compare.
  task automatic cycle(input bit v, input byte_t d);
    bit    hs, hold_chk;
    byte_t held;
    bit    e_start, e_ferr, e_ovr, e_done;
    i_rx_valid = v;
    i_rx_data  = v ? d : 8'h00;
    hs         = o_tx_valid && i_tx_ready && !i_reset;
    hold_chk   = o_tx_valid && !i_tx_ready && !i_reset;
    held       = o_tx_data;
    e_start = 0; e_ferr = 0; e_ovr = 0; e_done = 0;
    if (hs) begin
      got_q.push_back(o_tx_data);
      if (got_q.size() == 1) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
    end
    if (i_reset) begin
      phase = P_COLLECT; frame_q.delete(); got_q.delete();
      idle_cnt = 0; sent_cnt = 0; model_blk = '0;
    end else begin
      if (v) begin
        if (phase == P_COLLECT) begin
          model_blk[frame_q.size()*8 +: 8] = d;
          frame_q.push_back(d);
          idle_cnt = 0;
          if (frame_q.size() == N) begin
            e_start = 1; phase = P_AWAIT; frame_q.delete();
          end
        end else begin
          e_ovr = 1; n_ovr_exp++;
        end
      end else if (phase == P_COLLECT && frame_q.size() > 0) begin
        idle_cnt++;
        if (idle_cnt == G) begin
          frame_q.delete(); idle_cnt = 0; e_ferr = 1; n_ferr_exp++;
        end
      end
      if (i_aes_done && phase == P_AWAIT) begin
        phase = P_SEND; exp_tx = i_aes_result; sent_cnt = 0;
      end
      if (hs && phase == P_SEND) begin
        sent_cnt++;
        if (sent_cnt == N) begin
          e_done = 1; phase = P_COLLECT;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (o_frame_error) n_ferr_dut++;
    if (o_rx_overrun) n_ovr_dut++;
    check("aes_start", 128'(o_aes_start), 128'(e_start));
    check("frame_error", 128'(o_frame_error), 128'(e_ferr));
    check("rx_overrun", 128'(o_rx_overrun), 128'(e_ovr));
    check("frame_done", 128'(o_frame_done), 128'(e_done));
    check("aes_block", o_aes_block, model_blk);
    if (hold_chk) begin
      check("hold_valid", 128'(o_tx_valid), 128'(1));
      check("hold_data", 128'(o_tx_data), 128'(held));
    end
    if (e_done) begin
      check("tx_count", 128'(got_q.size()), 128'(N));
      check("tx_bytes", pack_q(got_q), exp_tx);
      check("tx_valid_after_done", 128'(o_tx_valid), 128'(0));
      check("busy_after_done", 128'(o_busy), 128'(0));
      got_q.delete();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic send_frame(input int nbytes, input int maxgap);
    for (int i = 0; i < nbytes; i++) begin
      cycle(1'b1, byte_t'($urandom));
      if (i < nbytes - 1) idle(int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic launch_aes(input logic [127:0] r, input int wait_cycles, input bit inject);
    for (int i = 0; i < wait_cycles; i++) cycle(inject && ($urandom_range(0, 2) == 0), byte_t'($urandom));
    i_aes_result = r;
    i_aes_done   = 1'b1;
    cycle(1'b0, 8'h00);
    i_aes_done   = 1'b0;
  endtask

  // ready_mode: 0 always ready, 1 ready one cycle in three, 2 random.
  task automatic run_tx(input int ready_mode, input bit inject);
    int n = 0;
    while (phase != P_COLLECT && n < 400) begin
      case (ready_mode)
        0:       i_tx_ready = 1'b1;
        1:       i_tx_ready = (cyc % 3 == 0);
        default: i_tx_ready = 1'($urandom_range(0, 1));
      endcase
      cycle(inject && ($urandom_range(0, 3) == 0), byte_t'($urandom));
      n++;
    end
    check("tx_timeout", 128'(phase), 128'(P_COLLECT));
    i_tx_ready = 1'b0;
  endtask

  initial begin
    int ferr_before;
    int ovr_before;
    i_reset = 1'b1; i_rx_valid = 1'b0; i_rx_data = '0;
    i_aes_done = 1'b0; i_aes_result = '0; i_tx_ready = 1'b0;
    phase = P_COLLECT; idle_cnt = 0; sent_cnt = 0; cyc = 0;
    first_hs_cyc = 0; last_hs_cyc = 0; model_blk = '0; exp_tx = '0;
    n_ferr_dut = 0; n_ferr_exp = 0; n_ovr_dut = 0; n_ovr_exp = 0;

    // Reset state
    idle(2);
    check("rst_block", o_aes_block, 128'h0);
    check("rst_start", 128'(o_aes_start), 128'(0));
    check("rst_tx_data", 128'(o_tx_data), 128'(0));
    check("rst_tx_valid", 128'(o_tx_valid), 128'(0));
    check("rst_busy", 128'(o_busy), 128'(0));
    check("rst_flags", 128'({o_frame_done, o_frame_error, o_rx_overrun}), 128'(0));
    i_reset = 1'b0;
    idle(3);

    // Test 1: bytes 0x00..0x0F spaced 20 cycles
    for (int k = 0; k < N; k++) begin
      cycle(1'b1, byte_t'(k));
      if (k < N - 1) idle(19);
    end
    check("t1_block", o_aes_block, 128'h0F0E0D0C0B0A09080706050403020100);
    check("t1_busy", 128'(o_busy), 128'(1));
    idle(3);
    check("t1_tx_idle", 128'(o_tx_valid), 128'(0));

    // Test 2: fixed result, always ready, 16 consecutive transfers
    i_tx_ready = 1'b1;
    launch_aes(128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, 0, 1'b0);
    check("t2_first_byte", 128'(o_tx_data), 128'hF0);
    run_tx(0, 1'b0);
    check("t2_consecutive", 128'(last_hs_cyc - first_hs_cyc), 128'(N - 1));
    check("t2_exp_result", exp_tx, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
    check("t2_busy", 128'(o_busy), 128'(0));

    // Test 3: random frame, backpressure one-in-three
    send_frame(N, 30);
    res = {$urandom, $urandom, $urandom, $urandom};
    launch_aes(res, int'($urandom_range(1, 10)), 1'b0);
    run_tx(1, 1'b0);

    // Test 4: partial frame times out, then a normal frame
    ferr_before = n_ferr_dut;
    send_frame(5, 10);
    check("t4_busy_partial", 128'(o_busy), 128'(1));
    idle(G);
    check("t4_one_error", 128'(n_ferr_dut - ferr_before), 128'(1));
    check("t4_busy_cleared", 128'(o_busy), 128'(0));
    idle(5);
    send_frame(N, 20);
    res = {$urandom, $urandom, $urandom, $urandom};
    launch_aes(res, 4, 1'b0);
    run_tx(2, 1'b0);

    // Test 5: byte on the expiry cycle, overruns during WAIT_AES/SEND
    ferr_before = n_ferr_dut;
    ovr_before  = n_ovr_dut;
    for (int k = 0; k < N; k++) begin
      cycle(1'b1, byte_t'($urandom));
      if (k < N - 1) idle((k % 4 == 1) ? G - 1 : int'($urandom_range(0, 5)));
    end
    check("t5_no_error", 128'(n_ferr_dut - ferr_before), 128'(0));
    res = {$urandom, $urandom, $urandom, $urandom};
    launch_aes(res, 8, 1'b1);
    run_tx(2, 1'b1);
    check("t5_overrun_seen", 128'(n_ovr_dut > ovr_before), 128'(1));

    // Test 6: reset mid-SEND, then a stray aes_done in COLLECT
    send_frame(N, 3);
    res = {$urandom, $urandom, $urandom, $urandom};
    launch_aes(res, 2, 1'b0);
    i_tx_ready = 1'b1;
    for (int n = 0; n < 100 && sent_cnt < 7; n++) cycle(1'b0, 8'h00);
    check("t6_at_byte7", 128'(sent_cnt), 128'(7));
    i_tx_ready = 1'b0;
    i_reset = 1'b1;
    cycle(1'b0, 8'h00);
    i_reset = 1'b0;
    check("t6_valid_low", 128'(o_tx_valid), 128'(0));
    check("t6_busy_low", 128'(o_busy), 128'(0));
    i_aes_result = 128'h1234;
    i_aes_done   = 1'b1;
    cycle(1'b0, 8'h00);
    i_aes_done   = 1'b0;
    i_tx_ready   = 1'b1;
    idle(4);
    check("t6_stray_done_valid", 128'(o_tx_valid), 128'(0));
    check("t6_stray_done_busy", 128'(o_busy), 128'(0));
    i_tx_ready   = 1'b0;

    // Recovery frame after reset
    send_frame(N, 8);
    res = {$urandom, $urandom, $urandom, $urandom};
    launch_aes(res, 3, 1'b1);
    run_tx(2, 1'b1);

    check("total_frame_errors", 128'(n_ferr_dut), 128'(n_ferr_exp));
    check("total_overruns", 128'(n_ovr_dut), 128'(n_ovr_exp));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
